// File: rtl/uart_tx_arb.sv
// ============================================================================
// Module   : uart_tx_arb
// Purpose  : Four-way arbiter in front of a UART transmitter. Picks one
//            pending byte while idle, pulses ack/tx_start_flag, then holds
//            off new grants for one frame time plus an inter-frame gap.
//            Round-robin by default. With UART_TX_ARB_FIXED_PRIO_EN defined,
//            the arbiter uses fixed priority (0 highest) and has no pointer.
// Ports    : sys_clk        - clock, rising edge
//            sys_rst        - synchronous active-high reset
//            req[3:0]       - per-requester byte pending
//            req_data[31:0] - byte i at req_data[8*i+7:8*i]
//            ack[3:0]       - one-cycle accept pulse, one-hot or zero
//            tx_start_flag  - one-cycle start pulse to the transmitter
//            tx_data[7:0]   - granted byte, held until the next grant
//            grant_id[1:0]  - index of the last granted requester
//            busy           - frame or inter-frame gap in progress
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arb #(
    parameter int CLK_PER_BIT = 5208,
    parameter int FRAME_BITS  = 10,
    parameter int GAP_CYCLES  = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  ack,
    output logic        tx_start_flag,
    output logic [7:0]  tx_data,
    output logic [1:0]  grant_id,
    output logic        busy
);

    localparam int c_FRAME_LEN = FRAME_BITS * CLK_PER_BIT;
    localparam int c_CNT_MAX   = (c_FRAME_LEN > GAP_CYCLES) ? c_FRAME_LEN : GAP_CYCLES;
    // One bit of headroom above the largest terminal count, so the counter
    // can never wrap before its compare fires.
    localparam int CNT_W       = $clog2(c_CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] c_FRAME_LAST = CNT_W'(c_FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_ack;
    logic             r_start;
    logic [7:0]       r_tx_data;
    logic [1:0]       r_grant_id;
    logic             r_busy;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_ack_nxt;
    logic             w_start_nxt;
    logic [7:0]       w_tx_data_nxt;
    logic [1:0]       w_grant_id_nxt;
    logic             w_busy_nxt;

    logic [1:0]       w_base;     // first requester examined by the search
    logic [1:0]       w_idx;
    logic [1:0]       w_win;
    logic             w_found;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    assign w_base = 2'd0;
`else
    // Holds (last grant + 1) mod 4; the 2-bit add wraps naturally.
    logic [1:0] r_ptr;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_ptr <= 2'd0;
        end else if (r_state == c_ST_IDLE && w_found) begin
            r_ptr <= w_win + 2'd1;
        end
    end

    assign w_base = r_ptr;
`endif

    // Scan the four requesters starting at w_base; first pending one wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        w_idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_idx = w_base + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_ack_nxt      = 4'b0000;
        w_start_nxt    = 1'b0;
        w_tx_data_nxt  = r_tx_data;
        w_grant_id_nxt = r_grant_id;
        w_busy_nxt     = r_busy;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_ack_nxt      = 4'b0001 << w_win;
                    w_start_nxt    = 1'b1;
                    w_tx_data_nxt  = req_data[{w_win, 3'b000} +: 8];
                    w_grant_id_nxt = w_win;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = c_ST_WAIT;
                    w_cnt_nxt      = '0;
                end
            end
            c_ST_WAIT: begin
                if (r_cnt == c_FRAME_LAST) begin
                    w_state_nxt = c_ST_GAP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            c_ST_GAP: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_ack      <= 4'b0000;
            r_start    <= 1'b0;
            r_tx_data  <= 8'h00;
            r_grant_id <= 2'd0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ack      <= w_ack_nxt;
            r_start    <= w_start_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign ack           = r_ack;
    assign tx_start_flag = r_start;
    assign tx_data       = r_tx_data;
    assign grant_id      = r_grant_id;
    assign busy          = r_busy;

endmodule

`default_nettype wire

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 5208, meaning sys_clk cycles per UART bit.
REQ-002 SHALL have parameter FRAME_BITS, default 10, meaning bits per frame (start + 8 data + stop).
REQ-003 SHALL have parameter GAP_CYCLES, default 16, meaning idle cycles between frames; legal values are 1 or more.
REQ-004 SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port req, input, 4 bits: req[i]=1 means requester i has a byte pending.
REQ-007 SHALL have port req_data, input, 32 bits: byte for requester i is req_data[8*i+7:8*i].
REQ-008 SHALL have port ack, output, 4 bits: one-cycle pulse on ack[i] when requester i's byte is accepted.
REQ-009 SHALL have port tx_start_flag, output, 1 bit: one-cycle start pulse to the UART transmitter.
REQ-010 SHALL have port tx_data, output, 8 bits: byte presented to the transmitter; held stable until the next grant.
REQ-011 SHALL have port grant_id, output, 2 bits: index of the last granted requester.
REQ-012 SHALL have port busy, output, 1 bit: high while a frame or inter-frame gap is in progress.

Function
REQ-013 SHALL implement an FSM with three states: IDLE, WAIT (frame on line) and GAP (inter-frame spacing).
REQ-014 In IDLE with req!=0, the block SHALL select a winner i at that clock edge and register all of the following together: ack[i]=1, tx_data=byte i, grant_id=i, tx_start_flag=1, busy=1, state=WAIT, cnt=0.
REQ-015 Arbitration SHALL be round-robin: search order starts at (last grant+1) mod 4 and wraps; after reset, search starts at 0.
REQ-016 ack and tx_start_flag SHALL be high for exactly one cycle per grant; at most one ack bit SHALL be high at a time.
REQ-017 In WAIT, cnt SHALL increment each cycle; at cnt==FRAME_BITS*CLK_PER_BIT-1 the block SHALL move to GAP with cnt=0.
REQ-018 In GAP, cnt SHALL increment each cycle; at cnt==GAP_CYCLES-1 the block SHALL move to IDLE and busy SHALL fall.
REQ-019 Width rules:
- cnt SHALL be wide enough to hold FRAME_BITS*CLK_PER_BIT-1 (17 bits at defaults).
- cnt SHALL never wrap.
REQ-020 Start-to-start interval SHALL be exactly FRAME_BITS*CLK_PER_BIT+GAP_CYCLES+1 cycles when requests are back-to-back.
REQ-021 Requests in WAIT/GAP SHALL be ignored, neither acked nor latched.
REQ-022 A requester SHALL hold req and data until its ack; a req dropped before ack is not served and leaves no state.
REQ-023 A requester may re-assert req in the cycle after its ack; it SHALL then compete normally.

Reset
REQ-024 While sys_rst=1 at a clock edge, the block SHALL set:
- state=IDLE, cnt=0
- ack=0, tx_start_flag=0, busy=0
- tx_data=0, grant_id=0
- round-robin pointer so that requester 0 has highest priority.
REQ-025 Reset mid-frame SHALL abort immediately with no ack or start pulse in the reset cycle; the first grant MAY occur on the first edge after sys_rst falls.

Configuration
REQ-026 With macro UART_TX_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (requester 0 highest, 3 lowest) and the round-robin pointer SHALL be absent.
REQ-027 Without UART_TX_ARB_FIXED_PRIO_EN, round-robin per REQ-015 SHALL apply; all other behaviour is identical in both builds.

Verification (CLK_PER_BIT=4, FRAME_BITS=10, GAP_CYCLES=2, default build unless stated)
REQ-028 Reset, then req=4'b0010 with byte1=8'hA5 -> next cycle ack=4'b0010, tx_start_flag=1, tx_data=8'hA5, grant_id=1; busy high for 42 cycles.
REQ-029 req=4'b1111 held for the run, each requester dropping its req after its own ack -> grant order 0,1,2,3 with start pulses 43 cycles apart.
REQ-030 Define UART_TX_ARB_FIXED_PRIO_EN; req0 and req2 held continuously -> requester 0 is granted every frame and requester 2 is never acked.
REQ-031 req3 pulsed for one cycle during WAIT -> no ack and no start pulse; state timing is unchanged.
REQ-032 Assert sys_rst 10 cycles into WAIT with req=4'b0100 held -> busy=0 and all outputs at reset values; one cycle after release, ack=4'b0100 (pointer back to 0).
REQ-033 Back-to-back single requester: req0 re-asserted the cycle after each ack -> consecutive starts exactly 43 cycles apart with no missed frames.
